// File: rtl/rotate_cmd_fifo.sv
// rotate_cmd_fifo: queues byte-rotate commands, feeds the head entry to an
// external rotate-right shifter, and registers the returned result.
// Left rotates become the equivalent right rotate as they are written, so
// the shifter only ever has to rotate right.
module rotate_cmd_fifo #(
  parameter int DEPTH = 4  // power of two, 2..16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_data,
  input  logic [3:0] in_amt,
  input  logic       in_dir,
  output logic [7:0] sh_data,
  output logic [3:0] sh_amt,
  input  logic [7:0] sh_result,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_data,
  output logic [4:0] count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [7:0]    mem_data_q [DEPTH];
  logic [2:0]    mem_amt_q  [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [4:0]    count_q, count_d;
  logic          out_valid_q, out_valid_d;
  logic [7:0]    out_data_q, out_data_d;

  logic          push, pop;
  logic [2:0]    norm_amt;

  // Handshake decode: a full queue refuses input even if it pops this edge.
  always_comb begin
    in_ready = (count_q < 5'(DEPTH));
    push     = in_valid && in_ready;
    pop      = (count_q != 5'd0) && (!out_valid_q || out_ready);
  end

  // Normalise to a 3-bit right-rotate amount; amounts of 8 or more store 0.
  // A left rotate by a is a right rotate by (-a) mod 8, which maps 0 to 0.
  always_comb begin
    norm_amt = 3'd0;
    if (!in_amt[3]) begin
      norm_amt = in_dir ? (3'd0 - in_amt[2:0]) : in_amt[2:0];
    end
  end

  // Head entry goes to the shifter; drive zeros when the queue is empty.
  always_comb begin
    sh_data = 8'd0;
    sh_amt  = 4'd0;
    if (count_q != 5'd0) begin
      sh_data = mem_data_q[rd_ptr_q];
      sh_amt  = {1'b0, mem_amt_q[rd_ptr_q]};
    end
  end

  // Next-state for pointers, occupancy and the output register.
  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    if (push) wr_ptr_d = AW'(wr_ptr_q + 1'b1);
    if (pop) begin
      rd_ptr_d    = AW'(rd_ptr_q + 1'b1);
      out_valid_d = 1'b1;
      out_data_d  = sh_result;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 5'd1;
      2'b01:   count_d = count_q - 5'd1;
      default: count_d = count_q;
    endcase
  end

  // Control state, cleared asynchronously so reset drops everything queued.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= 5'd0;
      out_valid_q <= 1'b0;
      out_data_q  <= 8'd0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  // Entry storage; contents are only visible through count, so no reset.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_data_q[wr_ptr_q] <= in_data;
      mem_amt_q[wr_ptr_q]  <= norm_amt;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign count     = count_q;

endmodule

// File: tb/tb_rotate_cmd_fifo.sv
// Bench for rotate_cmd_fifo: directed vector table plus hand-written
// sequences for fill/drain, simultaneous push/pop and mid-cycle reset.
module tb_rotate_cmd_fifo;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic [3:0] in_amt;
  logic       in_dir;
  logic [7:0] sh_data;
  logic [3:0] sh_amt;
  logic [7:0] sh_result;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic [4:0] count;

  int n_vec = 0;
  int n_err = 0;

  rotate_cmd_fifo #(.DEPTH(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_amt    (in_amt),
    .in_dir    (in_dir),
    .sh_data   (sh_data),
    .sh_amt    (sh_amt),
    .sh_result (sh_result),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .count     (count)
  );

  always #5 clk = ~clk;

  // Downstream rotate-right shifter: uses all four amount bits, so a stray
  // sh_amt[3] shows up as a wrong result.
  logic [15:0] sh_dd;
  always_comb begin
    sh_dd     = {sh_data, sh_data} >> sh_amt;
    sh_result = sh_dd[7:0];
  end

  typedef struct {
    logic [7:0] data;
    logic [3:0] amt;
    logic       dir;
    logic [3:0] exp_amt;
    logic [7:0] exp_out;
  } vec_t;

  vec_t vecs [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_nowait(input logic [7:0] d, input logic [3:0] a, input logic dr);
    in_valid = 1'b1;
    in_data  = d;
    in_amt   = a;
    in_dir   = dr;
  endtask

  initial begin
    vecs[0] = '{8'hB4, 4'd1, 1'b0, 4'd1, 8'h5A};
    vecs[1] = '{8'h81, 4'd3, 1'b1, 4'd5, 8'h0C};
    vecs[2] = '{8'h3C, 4'hA, 1'b0, 4'd0, 8'h3C};
    vecs[3] = '{8'h3C, 4'd0, 1'b1, 4'd0, 8'h3C};
    vecs[4] = '{8'h0F, 4'd4, 1'b0, 4'd4, 8'hF0};
    vecs[5] = '{8'h80, 4'd7, 1'b1, 4'd1, 8'h40};
    vecs[6] = '{8'hA5, 4'hF, 1'b1, 4'd0, 8'hA5};
    vecs[7] = '{8'h96, 4'd7, 1'b0, 4'd7, 8'h2D};

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = 8'd0;
    in_amt    = 4'd0;
    in_dir    = 1'b0;
    out_ready = 1'b1;
    #3;
    check("rst_count", 32'(count), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_sh_data", 32'(sh_data), 32'd0);
    step();
    rst_n = 1'b1;

    // Table: one command at a time with out_ready held high.
    for (int i = 0; i < 8; i++) begin
      push_nowait(vecs[i].data, vecs[i].amt, vecs[i].dir);
      step();
      in_valid = 1'b0;
      check($sformatf("v%0d_sh_amt", i), 32'(sh_amt), 32'(vecs[i].exp_amt));
      check($sformatf("v%0d_sh_data", i), 32'(sh_data), 32'(vecs[i].data));
      check($sformatf("v%0d_count1", i), 32'(count), 32'd1);
      check($sformatf("v%0d_valid_lat", i), 32'(out_valid), 32'd0);
      step();
      check($sformatf("v%0d_out_valid", i), 32'(out_valid), 32'd1);
      check($sformatf("v%0d_out_data", i), 32'(out_data), 32'(vecs[i].exp_out));
      check($sformatf("v%0d_count0", i), 32'(count), 32'd0);
      step();
      check($sformatf("v%0d_valid_drop", i), 32'(out_valid), 32'd0);
      check($sformatf("v%0d_data_hold", i), 32'(out_data), 32'(vecs[i].exp_out));
    end

    // Fill with out_ready low: 6 offered, 5 held (4 queued + output reg).
    out_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      push_nowait(8'((i + 1) * 8'h11), 4'd0, 1'b0);
      step();
    end
    in_valid = 1'b0;
    check("fill_count", 32'(count), 32'd4);
    check("fill_in_ready", 32'(in_ready), 32'd0);
    check("fill_out_valid", 32'(out_valid), 32'd1);
    check("fill_out_data", 32'(out_data), 32'h11);
    step();
    check("fill_stall_data", 32'(out_data), 32'h11);
    check("fill_stall_count", 32'(count), 32'd4);
    out_ready = 1'b1;
    for (int i = 1; i < 5; i++) begin
      step();
      check($sformatf("drain%0d_data", i), 32'(out_data), 32'((i + 1) * 8'h11));
      check($sformatf("drain%0d_valid", i), 32'(out_valid), 32'd1);
      check($sformatf("drain%0d_count", i), 32'(count), 32'(4 - i));
    end
    step();
    check("drain_end_valid", 32'(out_valid), 32'd0);
    check("drain_end_count", 32'(count), 32'd0);
    check("drain_end_ready", 32'(in_ready), 32'd1);

    // count = 2 with output stalled, then push and pop together.
    out_ready = 1'b0;
    push_nowait(8'hA1, 4'd0, 1'b0); step();
    push_nowait(8'hA2, 4'd0, 1'b0); step();
    push_nowait(8'hA3, 4'd0, 1'b0); step();
    check("pp_pre_count", 32'(count), 32'd2);
    check("pp_pre_data", 32'(out_data), 32'hA1);
    out_ready = 1'b1;
    push_nowait(8'hA4, 4'd0, 1'b0); step();
    in_valid = 1'b0;
    check("pp_count", 32'(count), 32'd2);
    check("pp_data", 32'(out_data), 32'hA2);
    step();
    check("pp_drain_a3", 32'(out_data), 32'hA3);
    step();
    check("pp_drain_a4", 32'(out_data), 32'hA4);
    check("pp_drain_count", 32'(count), 32'd0);
    step();
    check("pp_drain_valid", 32'(out_valid), 32'd0);

    // Mid-cycle asynchronous reset with count = 3 and output pending.
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      push_nowait(8'(8'hC0 + i), 4'd2, 1'b1);
      step();
    end
    in_valid = 1'b0;
    check("ar_pre_count", 32'(count), 32'd3);
    check("ar_pre_valid", 32'(out_valid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("ar_count", 32'(count), 32'd0);
    check("ar_out_valid", 32'(out_valid), 32'd0);
    check("ar_out_data", 32'(out_data), 32'd0);
    check("ar_in_ready", 32'(in_ready), 32'd1);
    check("ar_sh_amt", 32'(sh_amt), 32'd0);
    #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    push_nowait(8'h0F, 4'd4, 1'b0);
    step();
    in_valid = 1'b0;
    check("ar_first_accept", 32'(count), 32'd1);
    step();
    check("ar_post_data", 32'(out_data), 32'hF0);
    check("ar_post_valid", 32'(out_valid), 32'd1);
    step();
    check("ar_no_stale", 32'(out_valid), 32'd0);
    check("ar_no_stale_cnt", 32'(count), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/rotate_cmd_fifo.md
ROTATE_CMD_FIFO -- requirements
Module: rotate_cmd_fifo

Interface
REQ-001 Parameter: DEPTH, 4, number of queued rotate commands; SHALL be a power of two in 2..16.
REQ-002 Port: clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-003 Port: rst_n  input  1  reset; one clock; reset is asynchronous and active-low.
REQ-004 Port: in_valid  input  1  upstream command valid.
REQ-005 Port: in_ready  output  1  block can accept a command this cycle.
REQ-006 Port: in_data  input  8  byte to rotate.
REQ-007 Port: in_amt  input  4  rotate amount.
REQ-008 Port: in_dir  input  1  0 = rotate right, 1 = rotate left.
REQ-009 Port: sh_data  output  8  byte driven to the downstream 8-bit rotate-right shifter.
REQ-010 Port: sh_amt  output  4  right-rotate amount driven to that shifter.
REQ-011 Port: sh_result  input  8  combinational rotated byte returned by that shifter.
REQ-012 Port: out_valid  output  1  out_data holds a result.
REQ-013 Port: out_ready  input  1  downstream consumes out_data.
REQ-014 Port: out_data  output  8  registered rotate result.
REQ-015 Port: count  output  5  number of commands held in the queue, excluding the output register.

Function
REQ-016 Accept: a command SHALL be written to the queue on a rising edge where in_valid and in_ready are both 1.
REQ-017 in_ready SHALL be 1 iff count < DEPTH; no same-cycle bypass when full, even if a pop occurs that edge.
REQ-018 Normalisation at write, right (in_dir=0): stored amount = in_amt if in_amt < 8, else 0.
REQ-019 Normalisation at write, left (in_dir=1): stored amount = (8 - in_amt) mod 8 if in_amt < 8, else 0; a left amount of 0 SHALL store 0.
REQ-020 Each queue entry SHALL hold the 8-bit data and the 3-bit normalised amount; sh_amt[3] SHALL always be 0.
REQ-021 When count > 0, sh_data/sh_amt SHALL combinationally present the head entry; when count = 0 they SHALL be 0.
REQ-022 Pop: on an edge where count > 0 and (out_valid = 0 or out_ready = 1), out_data SHALL load sh_result, out_valid SHALL go to 1, and the head entry SHALL be removed.
REQ-023 On an edge where out_ready = 1 and no pop occurs, out_valid SHALL go to 0 and out_data SHALL hold its value.
REQ-024 Latency: with the queue empty and out_valid = 0, a command accepted on edge k SHALL appear on out_data with out_valid = 1 from edge k+1.
REQ-025 Ordering: results SHALL leave in acceptance order; none SHALL be dropped or duplicated.
REQ-026 Push and pop on the same edge SHALL leave count unchanged.
REQ-027 Read/write pointers SHALL wrap modulo DEPTH; total capacity is DEPTH + 1 commands (queue plus output register).
REQ-028 out_data/out_valid SHALL be stable while out_valid = 1 and out_ready = 0.

Reset
REQ-029 While rst_n = 0, count, pointers, out_valid and out_data SHALL be 0 immediately, independent of clk; in_ready SHALL be 1.
REQ-030 Reset asserted mid-operation SHALL discard all queued commands and any pending output.
REQ-031 The first rising edge after rst_n deasserts SHALL be able to accept a command.

Verification
REQ-032 Push 8'hB4, amt 1, right, out_ready = 1 -> sh_amt = 1; out_data = 8'h5A with out_valid = 1 one edge after accept.
REQ-033 Push 8'h81, amt 3, left -> sh_amt = 5; out_data = 8'h0C.
REQ-034 Push 8'h3C, amt 4'hA, right, then 8'h3C, amt 0, left -> both sh_amt = 0; out_data = 8'h3C both times.
REQ-035 out_ready = 0, 6 pushes offered (DEPTH = 4) -> 5 accepted, count = 4, in_ready = 0; then out_ready = 1 -> 5 results in order; count = 0, in_ready = 1.
REQ-036 count = 2, push and pop on the same edge -> count stays 2; result order preserved.
REQ-037 count = 3, out_valid = 1, rst_n pulsed low between clock edges -> count = 0 and out_valid = 0 before the next edge; next push 8'h0F, amt 4, right -> out_data = 8'hF0.
